// File: rtl/canvas_write_scheduler.sv
// Arbitrates the single canvas write port between the freehand tool and a raster layer-clear sweep.
// Optional feature: define CANVAS_CLEAR_ALL_EN to let clear_layer=0 sweep every layer at once.
module canvas_write_scheduler #(
  parameter int WIDTH = 640,
  parameter int HEIGHT = 480,
  parameter int LAYERS = 4,
  parameter int COLOR_WIDTH = 4,
  parameter logic [COLOR_WIDTH-1:0] COLOR_NONE = '0,
  localparam int XW = $clog2(WIDTH),
  localparam int YW = $clog2(HEIGHT)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tool_valid,
  output logic                   tool_ready,
  input  logic [XW-1:0]          tool_x,
  input  logic [YW-1:0]          tool_y,
  input  logic [COLOR_WIDTH-1:0] tool_color,
  input  logic [2:0]             tool_layer,
  input  logic [LAYERS-1:0]      layer_visible,
  input  logic                   clear_req,
  input  logic [2:0]             clear_layer,
  output logic                   clear_busy,
  output logic                   clear_done,
  output logic                   tool_dropped,
  output logic [XW-1:0]          wr_x,
  output logic [YW-1:0]          wr_y,
  output logic [COLOR_WIDTH-1:0] wr_color,
  output logic [LAYERS-1:0]      wr_en
);
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  localparam logic [2:0]    LAYER_MAX = 3'(LAYERS);
  localparam logic [XW-1:0] X_LAST    = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(HEIGHT - 1);

  state_t                   state_q, state_d;
  logic [XW-1:0]            cx_q, cx_d;
  logic [YW-1:0]            cy_q, cy_d;
  logic [2:0]               clr_layer_q, clr_layer_d;
  logic                     last_tool_q, last_tool_d;
  logic [XW-1:0]            wr_x_q, wr_x_d;
  logic [YW-1:0]            wr_y_q, wr_y_d;
  logic [COLOR_WIDTH-1:0]   wr_color_q, wr_color_d;
  logic [LAYERS-1:0]        wr_en_q, wr_en_d;
  logic                     tool_dropped_q, tool_dropped_d;
  logic                     clear_done_q, clear_done_d;

  logic                     in_clear, sweep_all, req_ok, tool_vis;
  logic                     eligible, tool_grant, clear_grant;
  logic [LAYERS-1:0]        tool_sel, clr_sel;

`ifdef CANVAS_CLEAR_ALL_EN
  logic clr_all_q, clr_all_d;
  assign sweep_all = clr_all_q;
  assign req_ok    = (clear_layer <= LAYER_MAX);
`else
  assign sweep_all = 1'b0;
  assign req_ok    = (clear_layer != 3'd0) && (clear_layer <= LAYER_MAX);
`endif

  // Layer numbers are 1-based; 0 and values above LAYERS select nothing.
  always_comb begin
    tool_vis = 1'b0;
    tool_sel = '0;
    clr_sel  = '0;
    for (int i = 0; i < LAYERS; i++) begin
      if (tool_layer == 3'(i + 1)) begin
        tool_vis    = layer_visible[i];
        tool_sel[i] = 1'b1;
      end
      if (clr_layer_q == 3'(i + 1)) clr_sel[i] = 1'b1;
    end
  end

  assign in_clear    = (state_q == CLEAR);
  assign tool_ready  = !in_clear || (!last_tool_q && !sweep_all);
  assign eligible    = tool_valid && tool_vis &&
                       !(in_clear && (sweep_all || (tool_layer == clr_layer_q)));
  assign tool_grant  = eligible && tool_ready;
  assign clear_grant = in_clear && !tool_grant;

  always_comb begin
    state_d        = state_q;
    cx_d           = cx_q;
    cy_d           = cy_q;
    clr_layer_d    = clr_layer_q;
    last_tool_d    = last_tool_q;
    wr_x_d         = wr_x_q;
    wr_y_d         = wr_y_q;
    wr_color_d     = wr_color_q;
    wr_en_d        = '0;
    tool_dropped_d = tool_valid && !eligible;
    clear_done_d   = (state_q == DONE);
`ifdef CANVAS_CLEAR_ALL_EN
    clr_all_d      = clr_all_q;
`endif
    case (state_q)
      IDLE: begin
        if (clear_req && req_ok) begin
          state_d     = CLEAR;
          clr_layer_d = clear_layer;
          cx_d        = '0;
          cy_d        = '0;
          last_tool_d = 1'b0;
`ifdef CANVAS_CLEAR_ALL_EN
          clr_all_d   = (clear_layer == 3'd0);
`endif
        end
      end
      CLEAR: begin
        last_tool_d = tool_grant;
        // The sweep position only moves on cycles the clear engine owns the bus.
        if (clear_grant) begin
          if (cx_q == X_LAST) begin
            cx_d = '0;
            if (cy_q == Y_LAST) begin
              cy_d    = '0;
              state_d = DONE;
            end else begin
              cy_d = cy_q + YW'(1);
            end
          end else begin
            cx_d = cx_q + XW'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (tool_grant) begin
      wr_x_d     = tool_x;
      wr_y_d     = tool_y;
      wr_color_d = tool_color;
      wr_en_d    = tool_sel;
    end else if (clear_grant) begin
      wr_x_d     = cx_q;
      wr_y_d     = cy_q;
      wr_color_d = COLOR_NONE;
      wr_en_d    = sweep_all ? {LAYERS{1'b1}} : clr_sel;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cx_q           <= '0;
      cy_q           <= '0;
      clr_layer_q    <= '0;
      last_tool_q    <= 1'b0;
      wr_x_q         <= '0;
      wr_y_q         <= '0;
      wr_color_q     <= '0;
      wr_en_q        <= '0;
      tool_dropped_q <= 1'b0;
      clear_done_q   <= 1'b0;
`ifdef CANVAS_CLEAR_ALL_EN
      clr_all_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      cx_q           <= cx_d;
      cy_q           <= cy_d;
      clr_layer_q    <= clr_layer_d;
      last_tool_q    <= last_tool_d;
      wr_x_q         <= wr_x_d;
      wr_y_q         <= wr_y_d;
      wr_color_q     <= wr_color_d;
      wr_en_q        <= wr_en_d;
      tool_dropped_q <= tool_dropped_d;
      clear_done_q   <= clear_done_d;
`ifdef CANVAS_CLEAR_ALL_EN
      clr_all_q      <= clr_all_d;
`endif
    end
  end

  assign clear_busy   = in_clear;
  assign clear_done   = clear_done_q;
  assign tool_dropped = tool_dropped_q;
  assign wr_x         = wr_x_q;
  assign wr_y         = wr_y_q;
  assign wr_color     = wr_color_q;
  assign wr_en        = wr_en_q;
endmodule

// File: tb/tb_canvas_write_scheduler.sv
// Self-checking bench for canvas_write_scheduler: directed scenarios plus random traffic,
// compared every cycle against a pixel-index based reference model.
module tb_canvas_write_scheduler;
  localparam int W = 8;
  localparam int H = 8;
  localparam int L = 4;
`ifdef CANVAS_CLEAR_ALL_EN
  localparam int ALL_EN = 1;
`else
  localparam int ALL_EN = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tool_valid = 1'b0;
  logic       tool_ready;
  logic [2:0] tool_x = '0;
  logic [2:0] tool_y = '0;
  logic [3:0] tool_color = '0;
  logic [2:0] tool_layer = '0;
  logic [3:0] layer_visible = '0;
  logic       clear_req = 1'b0;
  logic [2:0] clear_layer = '0;
  logic       clear_busy, clear_done, tool_dropped;
  logic [2:0] wr_x, wr_y;
  logic [3:0] wr_color, wr_en;

  canvas_write_scheduler #(.WIDTH(W), .HEIGHT(H), .LAYERS(L), .COLOR_WIDTH(4)) dut (
    .clk(clk), .reset(reset),
    .tool_valid(tool_valid), .tool_ready(tool_ready),
    .tool_x(tool_x), .tool_y(tool_y), .tool_color(tool_color),
    .tool_layer(tool_layer), .layer_visible(layer_visible),
    .clear_req(clear_req), .clear_layer(clear_layer),
    .clear_busy(clear_busy), .clear_done(clear_done), .tool_dropped(tool_dropped),
    .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color), .wr_en(wr_en)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_fail = 0;

  // Reference model: sweep progress is a pixel index, arbitration a "tool just wrote" flag.
  bit         m_busy, m_done, m_all, m_tool_last;
  int         m_pix, m_layer;
  logic [2:0] e_x, e_y;
  logic [3:0] e_c, e_en;
  logic       e_drop, e_done;

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_all = 0; m_tool_last = 0; m_pix = 0; m_layer = 0;
    e_x = '0; e_y = '0; e_c = '0; e_en = '0; e_drop = 1'b0; e_done = 1'b0;
  endtask

  task automatic model_step();
    int  tl, cl;
    bit  rdy, vis, elig, tw;
    tl   = int'(tool_layer);
    cl   = int'(clear_layer);
    rdy  = !m_busy || (!m_tool_last && !m_all);
    vis  = (tl >= 1 && tl <= L) ? layer_visible[tl-1] : 1'b0;
    elig = tool_valid && vis && !(m_busy && (m_all || tl == m_layer));
    tw   = elig && rdy;
    e_drop = tool_valid && !elig;
    e_done = m_done;
    e_en   = '0;
    if (tw) begin
      e_x = tool_x; e_y = tool_y; e_c = tool_color; e_en = 4'(1 << (tl - 1));
    end
    if (m_done) begin
      m_done = 0;
    end else if (m_busy) begin
      if (tw) begin
        m_tool_last = 1;
      end else begin
        m_tool_last = 0;
        e_x  = 3'(m_pix % W);
        e_y  = 3'(m_pix / W);
        e_c  = 4'd0;
        e_en = m_all ? 4'hF : 4'(1 << (m_layer - 1));
        m_pix++;
        if (m_pix == W * H) begin
          m_busy = 0;
          m_done = 1;
        end
      end
    end else if (clear_req && ((cl >= 1 && cl <= L) || (ALL_EN == 1 && cl == 0))) begin
      m_busy = 1; m_pix = 0; m_layer = cl; m_all = (cl == 0); m_tool_last = 0;
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    bit exp_rdy;
    if (reset) return;
    exp_rdy = !m_busy || (!m_tool_last && !m_all);
    n_vec++;
    if (wr_x !== e_x || wr_y !== e_y || wr_color !== e_c || wr_en !== e_en ||
        tool_dropped !== e_drop || clear_done !== e_done ||
        tool_ready !== exp_rdy || clear_busy !== m_busy) begin
      n_fail++;
      $display("FAIL model t=%0t: x %0d/%0d y %0d/%0d col %0d/%0d en %b/%b drop %b/%b done %b/%b rdy %b/%b busy %b/%b (got/exp)",
               $time, wr_x, e_x, wr_y, e_y, wr_color, e_c, wr_en, e_en, tool_dropped, e_drop,
               clear_done, e_done, tool_ready, exp_rdy, clear_busy, m_busy);
    end
  endtask

  // One clock: model follows the edge, DUT is checked on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else model_step();
    @(negedge clk);
    compare_all();
  endtask

  int n_wr, first_j, done_j, n_done, n_drop, n_all;
  bit found;

  initial begin
    model_reset();
    repeat (2) tick();
    reset = 1'b0;
    chk("reset_wr_en", wr_en, 0);
    chk("reset_tool_ready", tool_ready, 1);
    chk("reset_clear_busy", clear_busy, 0);
    chk("reset_clear_done", clear_done, 0);
    chk("reset_wr_x", wr_x, 0);

    // Basic tool write
    tool_valid = 1; tool_layer = 2; layer_visible = 4'b0010;
    tool_x = 3; tool_y = 5; tool_color = 7;
    tick();
    chk("tool_wr_en", wr_en, 2);
    chk("tool_wr_x", wr_x, 3);
    chk("tool_wr_y", wr_y, 5);
    chk("tool_wr_color", wr_color, 7);

    // Invisible layer, then layer 0
    tool_layer = 1;
    tick();
    chk("invisible_drop", tool_dropped, 1);
    chk("invisible_wr_en", wr_en, 0);
    tool_layer = 0;
    tick();
    chk("layer0_drop", tool_dropped, 1);
    chk("layer0_wr_en", wr_en, 0);
    tool_valid = 0;
    tick();
    chk("no_drop_idle", tool_dropped, 0);
    chk("hold_wr_x", wr_x, 3);

    // Clear of layer 3 with no tool traffic, re-request mid-sweep
    clear_layer = 3; clear_req = 1;
    tick();
    clear_req = 0;
    chk("busy_after_req", clear_busy, 1);
    chk("no_write_at_req", wr_en, 0);
    n_wr = 0; first_j = -1; done_j = -1; n_done = 0;
    for (int j = 1; j <= 70; j++) begin
      if (j == 30) begin clear_req = 1; clear_layer = 2; end
      else clear_req = 0;
      tick();
      if (wr_en == 4'b0100) begin
        if (first_j < 0) first_j = j;
        chk("sweep_order", int'(wr_x) + 8 * int'(wr_y), n_wr);
        chk("sweep_color", wr_color, 0);
        n_wr++;
      end
      if (clear_done) begin
        n_done++;
        if (done_j < 0) done_j = j;
      end
    end
    chk("sweep_writes", n_wr, 64);
    chk("first_write_cycle", first_j, 1);
    chk("done_cycle", done_j, 65);
    chk("done_pulses", n_done, 1);

    // Contention: continuous tool traffic on layer 1 while clearing layer 3
    tool_valid = 1; tool_layer = 1; layer_visible = 4'hF;
    tool_x = 2; tool_y = 6; tool_color = 5;
    clear_layer = 3; clear_req = 1;
    tick();
    clear_req = 0;
    done_j = -1; n_drop = 0;
    for (int j = 1; j <= 135; j++) begin
      tool_layer = (j == 40) ? 3'd3 : 3'd1;
      tick();
      if (j <= 128) chk("alternation", wr_en, (j % 2 == 1) ? 1 : 4);
      if (tool_dropped) n_drop++;
      if (clear_done && done_j < 0) done_j = j;
    end
    chk("contended_done_cycle", done_j, 129);
    chk("cleared_layer_drop", n_drop, 1);
    tool_valid = 0;
    tick();

    // Reset in the middle of a sweep
    clear_layer = 3; clear_req = 1;
    tick();
    clear_req = 0;
    found = 0;
    for (int j = 1; j <= 100; j++) begin
      tick();
      if (wr_en != 0 && wr_x == 4 && wr_y == 2) begin
        found = 1;
        break;
      end
    end
    chk("reach_pixel_4_2", found, 1);
    #2;
    reset = 1;
    model_reset();
    #1;
    chk("rst_mid_busy", clear_busy, 0);
    chk("rst_mid_wr_en", wr_en, 0);
    chk("rst_mid_done", clear_done, 0);
    tick();
    chk("rst_mid_done_next", clear_done, 0);
    reset = 0;
    clear_layer = 3; clear_req = 1;
    tick();
    clear_req = 0;
    tick();
    chk("restart_x", wr_x, 0);
    chk("restart_y", wr_y, 0);
    chk("restart_en", wr_en, 4);
    repeat (70) tick();

    // Out-of-range and layer-0 clear requests
    clear_layer = 5; clear_req = 1;
    tick();
    clear_req = 0;
    chk("clear5_ignored", clear_busy, 0);
    clear_layer = 0; clear_req = 1;
    tick();
    clear_req = 0;
    chk("clear0_busy", clear_busy, ALL_EN);
    n_all = 0;
    for (int j = 1; j <= 70; j++) begin
      tick();
      if (j == 10) chk("clear0_tool_ready", tool_ready, 1 - ALL_EN);
      if (wr_en == 4'hF) n_all++;
    end
    chk("clear0_all_writes", n_all, 64 * ALL_EN);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      tool_valid    = ($urandom_range(0, 3) != 0);
      tool_layer    = 3'($urandom_range(0, 5));
      layer_visible = 4'($urandom);
      tool_x        = 3'($urandom_range(0, 7));
      tool_y        = 3'($urandom_range(0, 7));
      tool_color    = 4'($urandom_range(0, 15));
      clear_req     = ($urandom_range(0, 40) == 0);
      clear_layer   = 3'($urandom_range(0, 5));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
